// File: rtl/demux_16b_1to2_reg.sv
// Registered 1-to-2 demultiplexer: steers one WIDTH-bit stream to port 0 or port 1 per in_sel.
// Latency: one cycle from an accepted input to outN_valid/outN_data; 1 word/cycle per port sustained.
// Backpressure: in_ready reflects only the addressed port (reload-in-place when that port drains).
//
// Optional feature macro: DEMUX_STATS_EN adds cnt0/cnt1 completed-transfer counters.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_data/in_sel/in_valid      producer side; in_ready is combinational from in_sel and port state
//   out0_data/out0_valid/out0_ready   port 0 holding register and handshake
//   out1_data/out1_valid/out1_ready   port 1 holding register and handshake
//   cnt0, cnt1                   [DEMUX_STATS_EN] per-port completed-transfer counts, 16-bit wrap
module demux_16b_1to2_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_t;

    port_state_t state0;
    port_state_t state1;

    logic load0;
    logic load1;

    assign out0_valid = (state0 == FULL);
    assign out1_valid = (state1 == FULL);

    // A port can take a word when it is empty or is being drained this same cycle.
    assign in_ready = in_sel ? (!out1_valid || out1_ready)
                             : (!out0_valid || out0_ready);

    assign load0 = in_valid && in_ready && !in_sel;
    assign load1 = in_valid && in_ready &&  in_sel;

    // Both per-port FSMs live in one block; data registers only move on a load,
    // so a held word stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state0    <= EMPTY;
            state1    <= EMPTY;
            out0_data <= '0;
            out1_data <= '0;
        end else begin
            if (load0) begin
                state0    <= FULL;
                out0_data <= in_data;
            end else if (out0_ready) begin
                state0 <= EMPTY;
            end

            if (load1) begin
                state1    <= FULL;
                out1_data <= in_data;
            end else if (out1_ready) begin
                state1 <= EMPTY;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    // Reset has priority, so a handshake coinciding with rst is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) cnt0 <= cnt0 + 16'd1;
            if (out1_valid && out1_ready) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_16b_1to2_reg.sv
// Testbench for demux_16b_1to2_reg: directed vector table, hand sequences, and a random run
// checked against per-port scoreboard queues and a small reference model of the port states.
// Outputs are sampled on the falling clock edge; inputs change 1 time unit after the rising edge.
module tb_demux_16b_1to2_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out0_data;
    logic        out0_valid;
    logic        out0_ready = 1'b0;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready = 1'b0;
`ifdef DEMUX_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    demux_16b_1to2_reg #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic        mon_en = 1'b0;
    logic        m0 = 1'b0;
    logic        m1 = 1'b0;
    logic        eir;
    logic        x0;
    logic        x1;
    logic [15:0] mc0 = '0;
    logic [15:0] mc1 = '0;
    logic [15:0] acc = '0;
    logic [15:0] popped;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always @(negedge clk) begin
        eir = in_sel ? (!m1 || out1_ready) : (!m0 || out0_ready);
        if (mon_en) begin
            chk("mon_in_ready", {31'd0, in_ready}, {31'd0, eir});
            chk("mon_out0_valid", {31'd0, out0_valid}, {31'd0, m0});
            chk("mon_out1_valid", {31'd0, out1_valid}, {31'd0, m1});
            if (m0 && q0.size() > 0) chk("mon_out0_data", {16'd0, out0_data}, {16'd0, q0[0]});
            if (m1 && q1.size() > 0) chk("mon_out1_data", {16'd0, out1_data}, {16'd0, q1[0]});
`ifdef DEMUX_STATS_EN
            chk("mon_cnt0", {16'd0, cnt0}, {16'd0, mc0});
            chk("mon_cnt1", {16'd0, cnt1}, {16'd0, mc1});
`endif
        end
        if (rst) begin
            m0 = 1'b0;
            m1 = 1'b0;
            mc0 = '0;
            mc1 = '0;
            acc = '0;
            q0.delete();
            q1.delete();
        end else begin
            if (m0 && out0_ready) begin
                mc0 = mc0 + 16'd1;
                if (q0.size() == 0) chk("mon_pop0_empty", 32'd1, 32'd0);
                else begin
                    popped = q0.pop_front();
                    if (mon_en) chk("mon_pop0", {16'd0, out0_data}, {16'd0, popped});
                end
            end
            if (m1 && out1_ready) begin
                mc1 = mc1 + 16'd1;
                if (q1.size() == 0) chk("mon_pop1_empty", 32'd1, 32'd0);
                else begin
                    popped = q1.pop_front();
                    if (mon_en) chk("mon_pop1", {16'd0, out1_data}, {16'd0, popped});
                end
            end
            x0 = in_valid && eir && !in_sel;
            x1 = in_valid && eir &&  in_sel;
            if (x0) begin q0.push_back(in_data); acc = acc + 16'd1; end
            if (x1) begin q1.push_back(in_data); acc = acc + 16'd1; end
            m0 = x0 ? 1'b1 : (out0_ready ? 1'b0 : m0);
            m1 = x1 ? 1'b1 : (out1_ready ? 1'b0 : m1);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic [15:0] d;
        logic        s;
        logic        v;
        logic        r0;
        logic        r1;
        logic        en;
        logic        ir;
        logic        v0;
        logic        v1;
        logic [15:0] d0;
        logic [15:0] d1;
    } vec_t;

    function automatic vec_t mk(logic r, logic [15:0] d, logic s, logic v, logic r0, logic r1,
                                logic en, logic ir, logic v0, logic v1,
                                logic [15:0] d0, logic [15:0] d1);
        vec_t t;
        t.r = r; t.d = d; t.s = s; t.v = v; t.r0 = r0; t.r1 = r1;
        t.en = en; t.ir = ir; t.v0 = v0; t.v1 = v1; t.d0 = d0; t.d1 = d1;
        return t;
    endfunction

    task automatic drive(input logic r, input logic [15:0] d, input logic s, input logic v,
                         input logic r0, input logic r1);
        rst = r; in_data = d; in_sel = s; in_valid = v; out0_ready = r0; out1_ready = r1;
    endtask

    vec_t tbl[16];

    initial begin
        //            rst data     sel v  r0 r1  en ir v0 v1 d0       d1
        tbl[0]  = mk(1, 16'h0000, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(1, 16'h0000, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 16'h0000);
        tbl[2]  = mk(0, 16'hBEEF, 1, 1, 0, 0,  1, 1, 0, 0, 16'h0000, 16'h0000);
        tbl[3]  = mk(0, 16'h0000, 1, 0, 0, 0,  1, 0, 0, 1, 16'h0000, 16'hBEEF);
        tbl[4]  = mk(0, 16'h0000, 1, 0, 0, 0,  1, 0, 0, 1, 16'h0000, 16'hBEEF);
        tbl[5]  = mk(0, 16'h0000, 1, 0, 0, 0,  1, 0, 0, 1, 16'h0000, 16'hBEEF);
        tbl[6]  = mk(0, 16'h0000, 1, 0, 0, 0,  1, 0, 0, 1, 16'h0000, 16'hBEEF);
        tbl[7]  = mk(0, 16'h0000, 1, 0, 0, 0,  1, 0, 0, 1, 16'h0000, 16'hBEEF);
        tbl[8]  = mk(0, 16'h0000, 1, 0, 0, 1,  1, 1, 0, 1, 16'h0000, 16'hBEEF);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 16'hBEEF);
        tbl[10] = mk(0, 16'h1234, 0, 1, 0, 0,  1, 1, 0, 0, 16'h0000, 16'hBEEF);
        tbl[11] = mk(0, 16'h9999, 0, 1, 0, 0,  1, 0, 1, 0, 16'h1234, 16'hBEEF);
        tbl[12] = mk(0, 16'h5678, 1, 1, 0, 0,  1, 1, 1, 0, 16'h1234, 16'hBEEF);
        tbl[13] = mk(0, 16'h0000, 0, 0, 0, 0,  1, 0, 1, 1, 16'h1234, 16'h5678);
        tbl[14] = mk(0, 16'h0000, 1, 0, 1, 1,  1, 1, 1, 1, 16'h1234, 16'h5678);
        tbl[15] = mk(0, 16'h0000, 0, 0, 0, 0,  1, 1, 0, 0, 16'h1234, 16'h5678);

        @(posedge clk); #1;

        // Reset, single route with hold, backpressure isolation
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].r0, tbl[i].r1);
            @(negedge clk);
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
                chk($sformatf("tbl%0d_out0_valid", i), {31'd0, out0_valid}, {31'd0, tbl[i].v0});
                chk($sformatf("tbl%0d_out1_valid", i), {31'd0, out1_valid}, {31'd0, tbl[i].v1});
                chk($sformatf("tbl%0d_out0_data", i), {16'd0, out0_data}, {16'd0, tbl[i].d0});
                chk($sformatf("tbl%0d_out1_data", i), {16'd0, out1_data}, {16'd0, tbl[i].d1});
            end
            mon_en = 1'b1;
            @(posedge clk); #1;
        end

        // Streaming 0x0001..0x0010 to port 0 with the consumer always ready
        for (int i = 1; i <= 17; i++) begin
            drive(1'b0, 16'(i), 1'b0, (i <= 16), 1'b1, 1'b0);
            @(negedge clk);
            if (i <= 16) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i >= 2) begin
                chk("stream_out0_valid", {31'd0, out0_valid}, 32'd1);
                chk("stream_out0_data", {16'd0, out0_data}, 32'(i - 1));
            end
            @(posedge clk); #1;
        end

        // Reset while both ports hold words
        drive(1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); @(posedge clk); #1;
        drive(1'b0, 16'hBBBB, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); @(posedge clk); #1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstmid_full0", {31'd0, out0_valid}, 32'd1);
        chk("rstmid_full1", {31'd0, out1_valid}, 32'd1);
        chk("rstmid_data0", {16'd0, out0_data}, 32'hAAAA);
        chk("rstmid_data1", {16'd0, out1_data}, 32'hBBBB);
        @(posedge clk); #1;
        drive(1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk); @(posedge clk); #1;
        drive(1'b0, 16'hC0DE, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstmid_v0_clr", {31'd0, out0_valid}, 32'd0);
        chk("rstmid_v1_clr", {31'd0, out1_valid}, 32'd0);
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_STATS_EN
        chk("rstmid_cnt0", {16'd0, cnt0}, 32'd0);
        chk("rstmid_cnt1", {16'd0, cnt1}, 32'd0);
`endif
        @(posedge clk); #1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstmid_route_v0", {31'd0, out0_valid}, 32'd1);
        chk("rstmid_route_d0", {16'd0, out0_data}, 32'hC0DE);
        chk("rstmid_route_v1", {31'd0, out1_valid}, 32'd0);
        @(posedge clk); #1;

        // Random traffic; the monitor checks every cycle
        for (int i = 0; i < 3200; i++) begin
            drive(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk); @(posedge clk); #1;
        end

`ifdef DEMUX_STATS_EN
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rand_cnt_sum", {16'd0, 16'(cnt0 + cnt1)},
            {16'd0, 16'(acc - 16'(q0.size() + q1.size()))});
        @(posedge clk); #1;
`endif

        // Drain and confirm every accepted word was delivered
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge clk); @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_q0_empty", 32'(q0.size()), 32'd0);
        chk("drain_q1_empty", 32'(q1.size()), 32'd0);
        chk("drain_v0", {31'd0, out0_valid}, 32'd0);
        chk("drain_v1", {31'd0, out1_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
